// File: rtl/if_flow_ctrl_pkg.sv
// Shared definitions for the IF-stage flow controller: FSM state encodings,
// redirect priority levels and the bubble instruction used by IF/ID on flush.
package if_ctrl_pkg;

  typedef enum logic [1:0] {
    IFC_RUN      = 2'd0,
    IFC_STALL    = 2'd1,
    IFC_WAIT_MEM = 2'd2,
    IFC_FLUSH    = 2'd3
  } ifc_state_e;

  // Higher value wins; equal priority lets the newer request replace the older one.
  localparam logic [1:0] PRIO_NONE   = 2'd0;
  localparam logic [1:0] PRIO_STALL  = 2'd1;
  localparam logic [1:0] PRIO_BRANCH = 2'd2;
  localparam logic [1:0] PRIO_EXC    = 2'd3;

  localparam logic [31:0] IFC_NOP = 32'hE600_0000;

  function automatic logic [1:0] req_prio(input logic is_exc);
    return is_exc ? PRIO_EXC : PRIO_BRANCH;
  endfunction

endpackage

// File: rtl/if_flow_ctrl_if.sv
// Request/control bundle between the ID/EX hazard logic and the IF flow controller.
// Extra performance-counter signals exist only when IF_CTRL_PERF_EN is defined.
interface if_flow_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              stall_req;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              exc_req;
  logic [ADDR_W-1:0] exc_vector;
  logic              imem_ready;

  logic              pc_write_en;
  logic [ADDR_W-1:0] branch_target_addr;
  logic              pc_hold;
  logic              ifid_stall;
  logic              ifid_flush;
  logic [1:0]        ctrl_state;

`ifdef IF_CTRL_PERF_EN
  logic [31:0]       redirect_cnt;
  logic [31:0]       stall_cnt;

  modport master (
    output stall_req, branch_taken, branch_target, exc_req, exc_vector, imem_ready,
    input  pc_write_en, branch_target_addr, pc_hold, ifid_stall, ifid_flush, ctrl_state,
    input  redirect_cnt, stall_cnt
  );

  modport slave (
    input  stall_req, branch_taken, branch_target, exc_req, exc_vector, imem_ready,
    output pc_write_en, branch_target_addr, pc_hold, ifid_stall, ifid_flush, ctrl_state,
    output redirect_cnt, stall_cnt
  );
`else
  modport master (
    output stall_req, branch_taken, branch_target, exc_req, exc_vector, imem_ready,
    input  pc_write_en, branch_target_addr, pc_hold, ifid_stall, ifid_flush, ctrl_state
  );

  modport slave (
    input  stall_req, branch_taken, branch_target, exc_req, exc_vector, imem_ready,
    output pc_write_en, branch_target_addr, pc_hold, ifid_stall, ifid_flush, ctrl_state
  );
`endif

endinterface

// File: rtl/if_flow_ctrl_redirect_buf.sv
// Single-entry redirect buffer: holds one target while instruction memory is busy.
// An exception replaces anything; a branch never replaces a pending exception.
module if_redirect_buf
  import if_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_is_exc,
  input  logic [ADDR_W-1:0] req_target,
  input  logic              commit,
  input  logic              clear,
  output logic [ADDR_W-1:0] win_target
);

  logic              valid_q;
  logic              is_exc_q;
  logic [ADDR_W-1:0] target_q;
  logic              take;

  // The incoming request wins if the slot is empty or it is at least as urgent.
  always_comb begin
    take = req_valid && (!valid_q || (req_prio(req_is_exc) >= req_prio(is_exc_q)));
  end

  assign win_target = take ? req_target : target_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      is_exc_q <= 1'b0;
      target_q <= '0;
    end else if (clear) begin
      valid_q  <= 1'b0;
      is_exc_q <= 1'b0;
    end else if (commit && take) begin
      valid_q  <= 1'b1;
      is_exc_q <= req_is_exc;
      target_q <= req_target;
    end
  end

endmodule

// File: rtl/if_flow_ctrl.sv
// IF-stage sequencing controller: turns exception/branch/load-use requests into
// registered PC and IF/ID controls. Optional counters under IF_CTRL_PERF_EN.
module if_flow_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                FLUSH_CYCLES = 1,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic          clk,
  input  logic          reset,
  if_flow_ctrl_if.slave bus
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  ifc_state_e        state_q, state_d;
  logic              pc_we_q, pc_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hold_q, hold_d;
  logic              istall_q, istall_d;
  logic              iflush_q, iflush_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              redirect;
  logic              req_is_exc;
  logic [ADDR_W-1:0] req_target;
  logic              buf_commit;
  logic              buf_clear;
  logic [ADDR_W-1:0] win_target;

  always_comb begin
    redirect   = bus.exc_req | bus.branch_taken;
    req_is_exc = bus.exc_req;
    req_target = bus.exc_req ? bus.exc_vector : bus.branch_target;
  end

  if_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (redirect),
    .req_is_exc (req_is_exc),
    .req_target (req_target),
    .commit     (buf_commit),
    .clear      (buf_clear),
    .win_target (win_target)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state_q;
    pc_we_d    = 1'b0;
    addr_d     = addr_q;
    hold_d     = 1'b0;
    istall_d   = 1'b0;
    iflush_d   = 1'b0;
    cnt_d      = cnt_q;
    buf_commit = 1'b0;
    buf_clear  = 1'b0;

    unique case (state_q)
      IFC_RUN, IFC_STALL, IFC_FLUSH: begin
        if (redirect) begin
          if (bus.imem_ready) begin
            pc_we_d  = 1'b1;
            addr_d   = win_target;
            iflush_d = 1'b1;
            cnt_d    = FLUSH_LOAD;
            state_d  = IFC_FLUSH;
          end else begin
            buf_commit = 1'b1;
            hold_d     = 1'b1;
            iflush_d   = 1'b1;
            state_d    = IFC_WAIT_MEM;
          end
        end else if (state_q == IFC_FLUSH) begin
          // Stall requests are ignored until the bubble sequence is complete.
          if (cnt_q == 2'd0) begin
            state_d = IFC_RUN;
          end else begin
            cnt_d    = cnt_q - 2'd1;
            iflush_d = 1'b1;
          end
        end else if (bus.stall_req) begin
          hold_d   = 1'b1;
          istall_d = 1'b1;
          state_d  = IFC_STALL;
        end else begin
          state_d = IFC_RUN;
        end
      end

      IFC_WAIT_MEM: begin
        if (bus.imem_ready) begin
          buf_clear = 1'b1;
          pc_we_d   = 1'b1;
          addr_d    = win_target;
          iflush_d  = 1'b1;
          cnt_d     = FLUSH_LOAD;
          state_d   = IFC_FLUSH;
        end else begin
          buf_commit = redirect;
          hold_d     = 1'b1;
          iflush_d   = 1'b1;
        end
      end

      default: state_d = IFC_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IFC_RUN;
      pc_we_q  <= 1'b0;
      addr_q   <= RESET_VECTOR;
      hold_q   <= 1'b0;
      istall_q <= 1'b0;
      iflush_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      pc_we_q  <= pc_we_d;
      addr_q   <= addr_d;
      hold_q   <= hold_d;
      istall_q <= istall_d;
      iflush_q <= iflush_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.pc_write_en        = pc_we_q;
  assign bus.branch_target_addr = addr_q;
  assign bus.pc_hold            = hold_q;
  assign bus.ifid_stall         = istall_q;
  assign bus.ifid_flush         = iflush_q;
  assign bus.ctrl_state         = state_q;

`ifdef IF_CTRL_PERF_EN
  logic [31:0] redirect_cnt_q;
  logic [31:0] stall_cnt_q;

  // Counters track the visible outputs, so they lag the request by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt_q <= 32'd0;
      stall_cnt_q    <= 32'd0;
    end else begin
      if (pc_we_q)  redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (istall_q) stall_cnt_q    <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.redirect_cnt = redirect_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_flow_ctrl.sv
// Bench for if_flow_ctrl: two instances (FLUSH_CYCLES 1 and 3) on shared stimulus,
// directed vector table, hand sequences, then randomized traffic against a reference model.
module tb_if_flow_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_req, branch_taken, exc_req, imem_ready;
  logic [31:0] branch_target, exc_vector;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_flow_ctrl_if #(.ADDR_W(32)) bus1 ();
  if_flow_ctrl_if #(.ADDR_W(32)) bus3 ();

  assign bus1.stall_req = stall_req;   assign bus3.stall_req = stall_req;
  assign bus1.branch_taken = branch_taken; assign bus3.branch_taken = branch_taken;
  assign bus1.branch_target = branch_target; assign bus3.branch_target = branch_target;
  assign bus1.exc_req = exc_req;       assign bus3.exc_req = exc_req;
  assign bus1.exc_vector = exc_vector; assign bus3.exc_vector = exc_vector;
  assign bus1.imem_ready = imem_ready; assign bus3.imem_ready = imem_ready;

  if_flow_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(1), .RESET_VECTOR(32'h0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  if_flow_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(3), .RESET_VECTOR(32'h0)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3));

  // Reference: remaining flush cycles, a waiting flag with one pending target, a stall flag.
  typedef struct {
    int          flush_left;
    bit          waiting;
    bit          stalled;
    bit          pend_exc;
    logic [31:0] pend_addr;
    logic        pwe;
    logic [31:0] addr;
  } model_t;

  model_t m1, m3;

  function automatic model_t modelStep(model_t m, int fc, logic rst, logic stall, logic br,
                                       logic [31:0] bt, logic exc, logic [31:0] ev, logic rdy);
    bit          was_flushing;
    logic        redir;
    logic [31:0] tgt;
    if (rst) begin
      m.flush_left = 0; m.waiting = 0; m.stalled = 0; m.pend_exc = 0;
      m.pwe = 0; m.addr = 32'h0;
      return m;
    end
    was_flushing = (m.flush_left > 0);
    if (was_flushing) m.flush_left--;
    redir = exc | br;
    tgt   = exc ? ev : bt;
    m.pwe = 0;
    if (m.waiting) begin
      if (redir && (exc || !m.pend_exc)) begin
        m.pend_addr = tgt; m.pend_exc = exc;
      end
      if (rdy) begin
        m.pwe = 1; m.addr = m.pend_addr; m.waiting = 0; m.pend_exc = 0; m.flush_left = fc;
      end
    end else if (redir) begin
      m.stalled = 0;
      if (rdy) begin
        m.pwe = 1; m.addr = tgt; m.flush_left = fc;
      end else begin
        m.waiting = 1; m.pend_addr = tgt; m.pend_exc = exc; m.flush_left = 0;
      end
    end else if (was_flushing) begin
      m.stalled = 0;
    end else begin
      m.stalled = stall;
    end
    return m;
  endfunction

  task automatic checkOutput(input int sel, input string name, input logic pwe,
                             input logic [31:0] addr, input logic hold, input logic istall,
                             input logic flush, input logic [1:0] st);
    logic [37:0] act, exp;
    if (sel == 1)
      act = {bus1.pc_write_en, bus1.branch_target_addr, bus1.pc_hold, bus1.ifid_stall,
             bus1.ifid_flush, bus1.ctrl_state};
    else
      act = {bus3.pc_write_en, bus3.branch_target_addr, bus3.pc_hold, bus3.ifid_stall,
             bus3.ifid_flush, bus3.ctrl_state};
    exp = {pwe, addr, hold, istall, flush, st};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got pwe=%b addr=%h hold=%b stall=%b flush=%b state=%0d, expected pwe=%b addr=%h hold=%b stall=%b flush=%b state=%0d",
               name, sel, act[37], act[36:5], act[4], act[3], act[2], act[1:0],
               pwe, addr, hold, istall, flush, st);
    end
  endtask

  task automatic checkModel(input int sel, input string name, input model_t m);
    logic [1:0] st;
    st = m.waiting ? 2'd2 : (m.flush_left > 0) ? 2'd3 : m.stalled ? 2'd1 : 2'd0;
    checkOutput(sel, name, m.pwe, m.addr, m.waiting | m.stalled, m.stalled,
                m.waiting | (m.flush_left > 0), st);
  endtask

  task automatic applyStimulus(input logic rst, input logic stall, input logic br,
                               input logic [31:0] bt, input logic exc, input logic [31:0] ev,
                               input logic rdy);
    reset = rst; stall_req = stall; branch_taken = br; branch_target = bt;
    exc_req = exc; exc_vector = ev; imem_ready = rdy;
    @(posedge clk);
    m1 = modelStep(m1, 1, rst, stall, br, bt, exc, ev, rdy);
    m3 = modelStep(m3, 3, rst, stall, br, bt, exc, ev, rdy);
    #1;
  endtask

  typedef struct {
    logic rst, stall, br; logic [31:0] bt; logic exc; logic [31:0] ev; logic rdy;
    logic pwe; logic [31:0] addr; logic hold, istall, flush; logic [1:0] st;
  } vec_t;

  localparam int NV = 29;
  vec_t tbl [NV];

  initial begin
    reset = 1'b1; stall_req = 0; branch_taken = 0; exc_req = 0; imem_ready = 1;
    branch_target = 0; exc_vector = 0;

    //          rst stl br  bt        exc ev         rdy  pwe addr      hld stl fl  st
    tbl[0]  = '{1, 0, 0, 32'h0,   0, 32'h0,   1,   0, 32'h0,   0, 0, 0, 2'd0};
    tbl[1]  = '{1, 0, 0, 32'h0,   0, 32'h0,   1,   0, 32'h0,   0, 0, 0, 2'd0};
    tbl[2]  = '{0, 0, 0, 32'h0,   0, 32'h0,   1,   0, 32'h0,   0, 0, 0, 2'd0};
    tbl[3]  = '{0, 0, 1, 32'h20,  0, 32'h0,   1,   1, 32'h20,  0, 0, 1, 2'd3};
    tbl[4]  = '{0, 0, 0, 32'h0,   0, 32'h0,   1,   0, 32'h20,  0, 0, 0, 2'd0};
    tbl[5]  = '{0, 1, 0, 32'h0,   0, 32'h0,   1,   0, 32'h20,  1, 1, 0, 2'd1};
    tbl[6]  = '{0, 1, 0, 32'h0,   0, 32'h0,   1,   0, 32'h20,  1, 1, 0, 2'd1};
    tbl[7]  = '{0, 1, 0, 32'h0,   0, 32'h0,   1,   0, 32'h20,  1, 1, 0, 2'd1};
    tbl[8]  = '{0, 0, 0, 32'h0,   0, 32'h0,   1,   0, 32'h20,  0, 0, 0, 2'd0};
    tbl[9]  = '{0, 1, 1, 32'h40,  1, 32'h100, 1,   1, 32'h100, 0, 0, 1, 2'd3};
    tbl[10] = '{0, 0, 0, 32'h0,   0, 32'h0,   1,   0, 32'h100, 0, 0, 0, 2'd0};
    tbl[11] = '{0, 0, 1, 32'h30,  0, 32'h0,   0,   0, 32'h100, 1, 0, 1, 2'd2};
    tbl[12] = '{0, 0, 0, 32'h0,   0, 32'h0,   0,   0, 32'h100, 1, 0, 1, 2'd2};
    tbl[13] = '{0, 0, 0, 32'h0,   1, 32'h80,  0,   0, 32'h100, 1, 0, 1, 2'd2};
    tbl[14] = '{0, 0, 0, 32'h0,   0, 32'h0,   0,   0, 32'h100, 1, 0, 1, 2'd2};
    tbl[15] = '{0, 0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h80,  0, 0, 1, 2'd3};
    tbl[16] = '{0, 0, 0, 32'h0,   0, 32'h0,   1,   0, 32'h80,  0, 0, 0, 2'd0};
    tbl[17] = '{0, 0, 0, 32'h0,   1, 32'h200, 0,   0, 32'h80,  1, 0, 1, 2'd2};
    tbl[18] = '{0, 0, 1, 32'h300, 0, 32'h0,   0,   0, 32'h80,  1, 0, 1, 2'd2};
    tbl[19] = '{0, 0, 0, 32'h0,   0, 32'h0,   1,   1, 32'h200, 0, 0, 1, 2'd3};
    tbl[20] = '{0, 0, 1, 32'h44,  0, 32'h0,   1,   1, 32'h44,  0, 0, 1, 2'd3};
    tbl[21] = '{0, 1, 0, 32'h0,   0, 32'h0,   1,   0, 32'h44,  0, 0, 0, 2'd0};
    tbl[22] = '{0, 0, 0, 32'h0,   0, 32'h0,   1,   0, 32'h44,  0, 0, 0, 2'd0};
    tbl[23] = '{0, 0, 1, 32'h500, 0, 32'h0,   0,   0, 32'h44,  1, 0, 1, 2'd2};
    tbl[24] = '{1, 0, 0, 32'h0,   0, 32'h0,   0,   0, 32'h0,   0, 0, 0, 2'd0};
    tbl[25] = '{0, 0, 0, 32'h0,   0, 32'h0,   1,   0, 32'h0,   0, 0, 0, 2'd0};
    tbl[26] = '{0, 0, 1, 32'h600, 0, 32'h0,   0,   0, 32'h0,   1, 0, 1, 2'd2};
    tbl[27] = '{0, 0, 0, 32'h0,   1, 32'h700, 1,   1, 32'h700, 0, 0, 1, 2'd3};
    tbl[28] = '{0, 0, 0, 32'h0,   0, 32'h0,   1,   0, 32'h700, 0, 0, 0, 2'd0};

    for (int i = 0; i < NV; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].stall, tbl[i].br, tbl[i].bt, tbl[i].exc, tbl[i].ev,
                    tbl[i].rdy);
      checkOutput(1, $sformatf("vec%0d", i), tbl[i].pwe, tbl[i].addr, tbl[i].hold,
                  tbl[i].istall, tbl[i].flush, tbl[i].st);
    end

    // Three-cycle flush, restart mid-flush, then reset while flushing.
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput(3, "fc3_reset", 0, 32'h0, 0, 0, 0, 2'd0);
    applyStimulus(0, 0, 1, 32'h20, 0, 0, 1);
    checkOutput(3, "fc3_pulse", 1, 32'h20, 0, 0, 1, 2'd3);
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    checkOutput(3, "fc3_flush2", 0, 32'h20, 0, 0, 1, 2'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput(3, "fc3_flush3", 0, 32'h20, 0, 0, 1, 2'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput(3, "fc3_done", 0, 32'h20, 0, 0, 0, 2'd0);
    applyStimulus(0, 0, 1, 32'h24, 0, 0, 1);
    checkOutput(3, "fc3_pulse2", 1, 32'h24, 0, 0, 1, 2'd3);
    applyStimulus(0, 0, 0, 0, 1, 32'h88, 1);
    checkOutput(3, "fc3_restart", 1, 32'h88, 0, 0, 1, 2'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput(3, "fc3_mid", 0, 32'h88, 0, 0, 1, 2'd3);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput(3, "fc3_rst_flush", 0, 32'h0, 0, 0, 0, 2'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput(3, "fc3_after_rst", 0, 32'h0, 0, 0, 0, 2'd0);

    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom % 100) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
                    $urandom, ($urandom % 16) == 0, $urandom, ($urandom % 4) != 0);
      checkModel(1, $sformatf("rand%0d", c), m1);
      checkModel(3, $sformatf("rand%0d", c), m3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
